add_accumulate_ctrl: RTL and testbench
======================================

Name: add_accumulate_ctrl

Overview:
Sequential register and control stage that feeds the 16-bit ripple and carry-lookahead adders and consumes their result.
- Holds an accumulator (operand A) and a switch-loaded operand B, and drives both to the adder's A/B inputs.
- On each Run press, it waits a programmable settle time, then captures Sum/CO back into the accumulator.
- It is the lab-top datapath between the switches/buttons and the combinational adder.

Parameters:
WIDTH, 16, datapath width; must match the adder instance.
SETTLE_CYCLES, 1, clock cycles the operands are held stable before Sum is captured; legal range 1..15, 0 is illegal.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-high reset.
Din  in  WIDTH  switch data for operand B.
Load_B  in  1  level; load Din into B (honoured in IDLE only).
Clear_A  in  1  level; clear accumulator and flags (honoured in IDLE only).
Run  in  1  level; start one add (one add per assertion).
Sum  in  WIDTH  result from the adder.
CO  in  1  carry-out from the adder.
Op_A  out  WIDTH  accumulator register, to adder A.
Op_B  out  WIDTH  B register, to adder B.
Carry  out  1  CO captured with the last result.
Ovf  out  1  signed overflow of the last add.
Busy  out  1  high while in SETTLE.
Done  out  1  one-cycle pulse after capture.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values:
  - Accumulator, B, Carry, Ovf, Busy, Done = 0.
  - State = IDLE; settle counter = 0.
  - Reset asserted mid-operation aborts the operation immediately; nothing is captured.
- Op_A and Op_B are direct register outputs and never change while in SETTLE, because loads are ignored outside IDLE.
- States: IDLE, SETTLE, DONE, HOLD.
- IDLE transitions:
  - Priority is Clear_A > Load_B > Run.
  - Clear_A: Acc<=0, Carry<=0, Ovf<=0; stay in IDLE.
  - Load_B: B<=Din; stay in IDLE.
  - Run (with neither of the above): counter<=SETTLE_CYCLES-1, go to SETTLE.
  - A Run held during a Clear or Load cycle is accepted on the next edge.
  - Clear_A and Load_B together: only Clear_A takes effect that cycle.
- SETTLE:
  - Busy=1.
  - If counter!=0: counter decrements.
  - If counter==0: Acc<=Sum, Carry<=CO, Ovf<=(Op_A[MSB]==Op_B[MSB])&&(Sum[MSB]!=Op_A[MSB]); go to DONE.
  - Load_B, Clear_A and Run are ignored.
- DONE: Done=1 for exactly one cycle. Next state is HOLD if Run=1, else IDLE.
- HOLD: wait for Run=0, then go to IDLE. Load_B and Clear_A are ignored in HOLD.
- Latency: Acc updates at the SETTLE_CYCLES-th rising edge after the edge that accepted Run. Done is high during the following cycle.
- Arithmetic: result is modulo 2^WIDTH. Carry is unsigned overflow; Ovf is two's-complement overflow. Both are replaced on every capture.
- Wrap-around: 0xFFFF+0x0001 gives Acc=0x0000, Carry=1, Ovf=0. Repeated presses keep accumulating.
- Run asserted in the same cycle Reset deasserts: sampled normally on the next edge.

Decomposition:
- Shared package adder_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, SETTLE, DONE, HOLD};
  - localparam ADDER_WIDTH = 16.
- One natural sub-module: reg_unit. It is a WIDTH-bit register with async active-high reset, synchronous clear and load, and clear priority over load. It is instantiated twice, for the accumulator and for B.
- The FSM and counter stay in the top of add_accumulate_ctrl.

Test Plan:
- Adder instantiated on the bench; SETTLE_CYCLES=1 unless stated.
- Basic add: Clear_A; Load_B Din=0x1234; Run one cycle, then low -> Acc=0x1234 one edge after acceptance, Done pulses once, Carry=0, Ovf=0. Run again -> Acc=0x2468.
- Wrap: Acc=0xFFFF (load via Load_B, then add to 0), B=0x0001; Run -> Acc=0x0000, Carry=1, Ovf=0. Acc=0x7FFF, B=0x0001 -> Acc=0x8000, Carry=0, Ovf=1.
- Held Run: B=0x0003, Run held high for 20 cycles -> exactly one add (Acc += 3); FSM sits in HOLD until Run falls; Done high for exactly 1 cycle.
- Ignored inputs and priority:
  - SETTLE_CYCLES=4: toggle Din/Load_B/Clear_A during SETTLE -> Op_B and Acc unchanged, Busy high for exactly 4 cycles.
  - In IDLE: Clear_A and Load_B together -> Acc=0, B unchanged.
- Async reset mid-operation: SETTLE_CYCLES=8, assert Reset between clock edges during SETTLE -> all outputs 0 immediately (before the next edge), no capture, state IDLE.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the adder lab datapath.
package adder_pkg;

   localparam int unsigned ADDER_WIDTH = 16;
   localparam int unsigned CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE,
      HOLD
   } ctrl_state_t;

   // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_accumulate_ctrl_reg_unit.sv
// WIDTH-bit register with async reset, synchronous clear and load (clear wins).
module reg_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= '0;
      end else if (clr_i) begin
         q_q <= '0;
      end else if (ld_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/add_accumulate_ctrl.sv
// Accumulator / operand-B register stage with a settle-then-capture controller
// sitting between the lab switches and the combinational adder.
module add_accumulate_ctrl
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH         = ADDER_WIDTH,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Din,
   input  logic             Load_B,
   input  logic             Clear_A,
   input  logic             Run,
   input  logic [WIDTH-1:0] Sum,
   input  logic             CO,
   output logic [WIDTH-1:0] Op_A,
   output logic [WIDTH-1:0] Op_B,
   output logic             Carry,
   output logic             Ovf,
   output logic             Busy,
   output logic             Done
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   ctrl_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic             idle_c;
   logic             capture_c;
   logic             acc_clr_c;
   logic             b_ld_c;

   // Register enables: loads only in IDLE, accumulator also written at capture.
   always_comb begin
      idle_c    = (state_q == IDLE);
      capture_c = (state_q == SETTLE) && (cnt_q == '0);
      acc_clr_c = idle_c && Clear_A;
      b_ld_c    = idle_c && !Clear_A && Load_B;
   end

   reg_unit #(.WIDTH(WIDTH)) u_acc (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (acc_clr_c),
      .ld_i  (capture_c),
      .d_i   (Sum),
      .q_o   (Op_A)
   );

   reg_unit #(.WIDTH(WIDTH)) u_b (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (1'b0),
      .ld_i  (b_ld_c),
      .d_i   (Din),
      .q_o   (Op_B)
   );

   // Controller: one add per Run assertion, HOLD absorbs a Run that stays high.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Clear_A) begin
                  carry_q <= 1'b0;
                  ovf_q   <= 1'b0;
               end else if (!Load_B && Run) begin
                  cnt_q   <= CNT_INIT;
                  busy_q  <= 1'b1;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  carry_q <= CO;
                  ovf_q   <= add_ovf(Op_A[WIDTH-1], Op_B[WIDTH-1], Sum[WIDTH-1]);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= Run ? HOLD : IDLE;
            end
            HOLD: begin
               if (!Run) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Carry = carry_q;
   assign Ovf   = ovf_q;
   assign Busy  = busy_q;
   assign Done  = done_q;

endmodule

// File: tb/tb_add_accumulate_ctrl.sv
// Bench for add_accumulate_ctrl: three instances (settle 1, 4, 8) each paired with
// a behavioural adder, checked against a transaction-level accumulator model.
module tb_add_accumulate_ctrl;

   localparam int unsigned W = 16;
   localparam int          N = 3;

   logic clk = 1'b0;
   logic rst;

   logic [W-1:0] din     [N];
   logic         load_b  [N];
   logic         clear_a [N];
   logic         run     [N];

   wire  [W-1:0] sum   [N];
   wire          co    [N];
   wire  [W-1:0] op_a  [N];
   wire  [W-1:0] op_b  [N];
   wire          carry [N];
   wire          ovf   [N];
   wire          busy  [N];
   wire          done  [N];

   int settle [N] = '{1, 4, 8};

   logic [W-1:0] m_acc   [N];
   logic [W-1:0] m_b     [N];
   logic         m_carry [N];
   logic         m_ovf   [N];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned SC = (g == 0) ? 1 : (g == 1) ? 4 : 8;

      assign {co[g], sum[g]} = {1'b0, op_a[g]} + {1'b0, op_b[g]};

      add_accumulate_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC)) u_dut (
         .Clk     (clk),
         .Reset   (rst),
         .Din     (din[g]),
         .Load_B  (load_b[g]),
         .Clear_A (clear_a[g]),
         .Run     (run[g]),
         .Sum     (sum[g]),
         .CO      (co[g]),
         .Op_A    (op_a[g]),
         .Op_B    (op_b[g]),
         .Carry   (carry[g]),
         .Ovf     (ovf[g]),
         .Busy    (busy[g]),
         .Done    (done[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input int k, input string what);
      check_eq($sformatf("i%0d %s op_a", k, what), 32'(op_a[k]), 32'(m_acc[k]));
      check_eq($sformatf("i%0d %s op_b", k, what), 32'(op_b[k]), 32'(m_b[k]));
      check_eq($sformatf("i%0d %s carry", k, what), 32'(carry[k]), 32'(m_carry[k]));
      check_eq($sformatf("i%0d %s ovf", k, what), 32'(ovf[k]), 32'(m_ovf[k]));
      check_eq($sformatf("i%0d %s busy", k, what), 32'(busy[k]), 32'd0);
      check_eq($sformatf("i%0d %s done", k, what), 32'(done[k]), 32'd0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_acc[k]   = '0;
         m_b[k]     = '0;
         m_carry[k] = 1'b0;
         m_ovf[k]   = 1'b0;
      end
   endtask

   // One IDLE cycle with Load_B and/or Clear_A; Clear_A wins when both are set.
   task automatic do_load(input int k, input logic [W-1:0] v, input logic ld, input logic clr);
      @(negedge clk);
      din[k]     = v;
      load_b[k]  = ld;
      clear_a[k] = clr;
      @(negedge clk);
      if (clr) begin
         m_acc[k]   = '0;
         m_carry[k] = 1'b0;
         m_ovf[k]   = 1'b0;
      end else if (ld) begin
         m_b[k] = v;
      end
      check_state(k, clr ? "clear" : "load");
      load_b[k]  = 1'b0;
      clear_a[k] = 1'b0;
   endtask

   // One Run press held for 'hold' edges; junk on Din/Load_B/Clear_A while not idle.
   task automatic do_add(input int k, input int hold);
      int           busy_n, done_n, first_busy, done_at, sa, sb;
      logic [W:0]   s;
      logic [W-1:0] e_acc;
      logic         e_c, e_v;
      s     = {1'b0, m_acc[k]} + {1'b0, m_b[k]};
      e_acc = s[W-1:0];
      e_c   = s[W];
      sa    = int'($signed(m_acc[k]));
      sb    = int'($signed(m_b[k]));
      e_v   = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      busy_n = 0; done_n = 0; first_busy = -1; done_at = -1;
      @(negedge clk);
      run[k] = 1'b1;
      for (int i = 1; i <= hold + settle[k] + 4; i++) begin
         @(negedge clk);
         if (i >= hold) run[k] = 1'b0;
         load_b[k]  = 1'b0;
         clear_a[k] = 1'b0;
         if (busy[k]) begin
            busy_n++;
            if (first_busy < 0) first_busy = i;
            check_eq($sformatf("i%0d settle op_a", k), 32'(op_a[k]), 32'(m_acc[k]));
            check_eq($sformatf("i%0d settle op_b", k), 32'(op_b[k]), 32'(m_b[k]));
         end
         if (done[k]) begin
            done_n++;
            done_at = i;
            check_eq($sformatf("i%0d result acc", k), 32'(op_a[k]), 32'(e_acc));
            check_eq($sformatf("i%0d result carry", k), 32'(carry[k]), 32'(e_c));
            check_eq($sformatf("i%0d result ovf", k), 32'(ovf[k]), 32'(e_v));
         end
         if (busy[k] || (done_n > 0 && i < hold)) begin
            din[k]     = W'($urandom);
            load_b[k]  = 1'($urandom);
            clear_a[k] = 1'($urandom);
         end
      end
      check_eq($sformatf("i%0d busy cycles", k), 32'(busy_n), 32'(settle[k]));
      check_eq($sformatf("i%0d busy start", k), 32'(first_busy), 32'd1);
      check_eq($sformatf("i%0d done pulses", k), 32'(done_n), 32'd1);
      check_eq($sformatf("i%0d done cycle", k), 32'(done_at), 32'(settle[k] + 1));
      m_acc[k]   = e_acc;
      m_carry[k] = e_c;
      m_ovf[k]   = e_v;
      check_state(k, "after add");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < N; k++) begin
         din[k] = '0; load_b[k] = 1'b0; clear_a[k] = 1'b0; run[k] = 1'b0;
      end
      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) check_state(k, "reset");
      rst = 1'b0;

      // Basic add and repeated press
      do_load(0, '0, 1'b0, 1'b1);
      do_load(0, 16'h1234, 1'b1, 1'b0);
      do_add(0, 1);
      do_add(0, 1);

      // Unsigned wrap, then signed overflow
      do_load(0, '0, 1'b0, 1'b1);
      do_load(0, 16'hFFFF, 1'b1, 1'b0);
      do_add(0, 1);
      do_load(0, 16'h0001, 1'b1, 1'b0);
      do_add(0, 1);
      do_load(0, '0, 1'b0, 1'b1);
      do_load(0, 16'h7FFF, 1'b1, 1'b0);
      do_add(0, 1);
      do_load(0, 16'h0001, 1'b1, 1'b0);
      do_add(0, 1);

      // Held Run, then Clear_A with Load_B together
      do_load(0, 16'h0003, 1'b1, 1'b0);
      do_add(0, 20);
      do_load(0, 16'hBEEF, 1'b1, 1'b1);

      // Longer settle with junk on the ignored inputs
      do_load(1, 16'h4321, 1'b1, 1'b0);
      do_add(1, 1);
      do_add(1, 3);

      // Randomized operation mix on every instance
      for (int k = 0; k < N; k++) begin
         for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 4))
               0:       do_load(k, '0, 1'b0, 1'b1);
               1, 2:    do_load(k, W'($urandom), 1'b1, 1'($urandom));
               default: do_add(k, int'($urandom_range(1, 6)));
            endcase
         end
      end
      do_load(2, 16'h1111, 1'b1, 1'b0);
      do_add(2, 1);

      // Async reset in the middle of a settle-8 operation
      @(negedge clk);
      run[2] = 1'b1;
      @(negedge clk);
      run[2] = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("i2 busy before reset", 32'(busy[2]), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < N; k++) begin
         check_eq($sformatf("i%0d async op_a", k), 32'(op_a[k]), 32'd0);
         check_eq($sformatf("i%0d async op_b", k), 32'(op_b[k]), 32'd0);
         check_eq($sformatf("i%0d async carry", k), 32'(carry[k]), 32'd0);
         check_eq($sformatf("i%0d async ovf", k), 32'(ovf[k]), 32'd0);
         check_eq($sformatf("i%0d async busy", k), 32'(busy[k]), 32'd0);
         check_eq($sformatf("i%0d async done", k), 32'(done[k]), 32'd0);
      end

      // Run rising as reset releases is accepted on the next edge
      @(negedge clk);
      rst    = 1'b0;
      run[0] = 1'b1;
      @(negedge clk);
      run[0] = 1'b0;
      check_eq("i0 run at reset release busy", 32'(busy[0]), 32'd1);
      @(negedge clk);
      check_eq("i0 run at reset release done", 32'(done[0]), 32'd1);
      repeat (10) @(negedge clk);
      for (int k = 0; k < N; k++) check_state(k, "post reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
